dac_frame_sched: RTL and testbench
==================================

Name: dac_frame_sched

Overview:
- Sequences stereo sample frames from two upstream sources into the DAC interface's single 24-bit word handshake, sending left then right.
- Selects between source 0 (DSP output) and source 1 (test/aux), switching only at frame boundaries.
- Buffers one frame ahead, fills underruns with zero or a repeat of the last frame, and applies frame-aligned mute.
- Sits directly upstream of the DAC interface, driving its word_valid, data_word and word_ready handshake.

Parameters:
- DW, 24, sample width in bits; matches the DAC data_word width.
- CNT_W, 16, underrun counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run streaming; low stops the output at the next frame boundary
- src_sel  in  1  selects source 0 or source 1; sampled only when the pending buffer is empty
- mute  in  1  output zero frames; sampled at frame load
- underrun_mode  in  1  0 = fill with zero frame, 1 = repeat last frame; sampled at frame load
- s0_valid  in  1  source 0 frame valid
- s0_ready  out  1  source 0 ready
- s0_left  in  DW  source 0 left sample
- s0_right  in  DW  source 0 right sample
- s1_valid  in  1  source 1 frame valid
- s1_ready  out  1  source 1 ready
- s1_left  in  DW  source 1 left sample
- s1_right  in  DW  source 1 right sample
- word_valid  out  1  to DAC interface
- word_ready  in  1  from DAC interface
- data_word  out  DW  to DAC interface
- word_is_right  out  1  1 while data_word carries the right sample
- active_src  out  1  source of the frame currently being output
- underrun_cnt  out  CNT_W  number of underruns, saturating

Behaviour:
- Clock and reset: single clock; rst is synchronous and active-high.
- Reset values: state IDLE; word_valid=0; data_word=0; word_is_right=0; active_src=0; underrun_cnt=0; pending buffer empty; current frame and last frame both zero.
- Pending buffer: one frame plus a source tag.
  - s0_ready = ~pend_full & ~src_sel, registered-equivalent; s1_ready = ~pend_full & src_sel. The unselected source is never ready.
  - A handshake (sX_valid & sX_ready) sets pend_full on the next cycle and captures left, right and the tag.
- States:
  - IDLE:
    - word_valid=0.
    - If enable & pend_full: load current from pending (zeros if mute), clear pend_full, go to SEND_L.
    - Underruns are never counted in IDLE.
  - SEND_L:
    - word_valid=1, data_word=cur_left, word_is_right=0.
    - On word_valid & word_ready: go to SEND_R.
  - SEND_R:
    - word_valid=1, data_word=cur_right, word_is_right=1.
    - On acceptance: frame boundary, see below.
- Frame boundary (right word accepted):
  - If enable=0: go to IDLE; word_valid=0 next cycle; pending frame retained.
  - Else if pend_full: load pending (zeros if mute), go to SEND_L.
  - Else (underrun): underrun_cnt+1, saturating at all-ones; load a zero frame if underrun_mode=0 or mute=1, otherwise reload the last frame; go to SEND_L. active_src is unchanged.
- last frame: updated with the pre-mute source data on every load from pending.
- active_src: takes the pending tag on every load from pending.
- Latency: a source handshake in cycle t while in IDLE with enable=1 gives word_valid=1 with the left sample at cycle t+2.
- Same-cycle events:
  - Right accepted with pend_full=0 while a source handshake also occurs: this is an underrun. The new frame goes into pending and is used at the next boundary.
  - A source handshake can never coincide with pend_full=1.
- word_ready while word_valid=0 is ignored.
- data_word and word_is_right hold stable while word_valid=1 & word_ready=0.
- A src_sel change mid-frame has no effect on the frame in flight. It affects only the next pending fill.
- rst mid-frame: all state returns to reset values on the next edge. The partial frame and the pending frame are discarded.

Test Plan:
1. Basic sequencing:
   - Stimulus: enable=1, src_sel=0; s0 sends frames (L=0x000001, R=0x000002) then (0x000003, 0x000004); word_ready held high.
   - Required: data_word sequence 1,2,3,4; word_is_right toggles 0,1,0,1; first word_valid 2 cycles after the first handshake; s1_ready stays 0 throughout.
2. Backpressure:
   - Stimulus: word_ready low for 5 cycles during SEND_L.
   - Required: data_word holds the left sample with word_valid=1; s0_ready=0 while pending is full; no data lost.
3. Underrun fill:
   - Stimulus: a single frame (0xABCDEF, 0x123456) with underrun_mode=1, then no more source frames.
   - Required: the frame repeats; underrun_cnt increments once per repeated frame.
   - Repeat with underrun_mode=0: zeros are output after the first frame.
   - Preload underrun_cnt to 0xFFFF: it stays 0xFFFF.
4. Source switch:
   - Stimulus: toggle src_sel to 1 while s0 frame N is in SEND_L.
   - Required: frame N completes from s0; the next frame comes from s1; active_src changes at the left word of the s1 frame.
5. Mute and enable:
   - Stimulus: assert mute mid-frame.
   - Required: the current frame completes unmuted; following frames are 0; pending frames are consumed.
   - Stimulus: drop enable during SEND_L.
   - Required: the right word is still sent; word_valid=0 in the following cycle; state is IDLE.
6. Reset mid-operation:
   - Stimulus: assert rst for 1 cycle in SEND_R with pend_full=1.
   - Required: all outputs at reset values the next cycle; no stale frame is output after enable.

Source files
------------

// File: rtl/dac_frame_sched_if.sv
// Source, control and DAC word handshake bundle around the stereo frame scheduler.
interface dac_frame_sched_if #(
    parameter int unsigned DW    = 24,
    parameter int unsigned CNT_W = 16
) ();
    logic             enable;
    logic             src_sel;
    logic             mute;
    logic             underrun_mode;
    logic             s0_valid;
    logic             s0_ready;
    logic [DW-1:0]    s0_left;
    logic [DW-1:0]    s0_right;
    logic             s1_valid;
    logic             s1_ready;
    logic [DW-1:0]    s1_left;
    logic [DW-1:0]    s1_right;
    logic             word_valid;
    logic             word_ready;
    logic [DW-1:0]    data_word;
    logic             word_is_right;
    logic             active_src;
    logic [CNT_W-1:0] underrun_cnt;

    // Scheduler side: masters the DAC word stream.
    modport master (
        input  enable, src_sel, mute, underrun_mode,
        input  s0_valid, s0_left, s0_right, s1_valid, s1_left, s1_right, word_ready,
        output s0_ready, s1_ready, word_valid, data_word, word_is_right, active_src, underrun_cnt
    );

    modport slave (
        output enable, src_sel, mute, underrun_mode,
        output s0_valid, s0_left, s0_right, s1_valid, s1_left, s1_right, word_ready,
        input  s0_ready, s1_ready, word_valid, data_word, word_is_right, active_src, underrun_cnt
    );
endinterface

// File: rtl/dac_frame_sched.sv
// Stereo frame scheduler: one-frame pending buffer, left/right word sequencing,
// frame-aligned source switch, mute and underrun fill toward the DAC interface.
module dac_frame_sched #(
    parameter int unsigned DW    = 24,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    dac_frame_sched_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND_L = 2'd1,
        ST_SEND_R = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    logic             r_pend_full;
    logic             r_pend_tag;
    logic [DW-1:0]    r_pend_l;
    logic [DW-1:0]    r_pend_r;
    logic [DW-1:0]    r_last_l;
    logic [DW-1:0]    r_last_r;
    logic [DW-1:0]    r_cur_r;
    logic [DW-1:0]    r_data_word;
    logic             r_word_valid;
    logic             r_word_is_right;
    logic             r_active_src;
    logic [CNT_W-1:0] r_underrun_cnt;

    logic             w_s0_hs;
    logic             w_s1_hs;
    logic             w_accept;
    logic             w_boundary;
    logic             w_load_pend;
    logic             w_underrun;
    logic             w_zero;
    logic [DW-1:0]    w_nxt_l;
    logic [DW-1:0]    w_nxt_r;

    assign bus.s0_ready      = ~r_pend_full & ~bus.src_sel;
    assign bus.s1_ready      = ~r_pend_full &  bus.src_sel;
    assign bus.word_valid    = r_word_valid;
    assign bus.data_word     = r_data_word;
    assign bus.word_is_right = r_word_is_right;
    assign bus.active_src    = r_active_src;
    assign bus.underrun_cnt  = r_underrun_cnt;

    assign w_s0_hs     = bus.s0_valid & ~r_pend_full & ~bus.src_sel;
    assign w_s1_hs     = bus.s1_valid & ~r_pend_full &  bus.src_sel;
    assign w_accept    = r_word_valid & bus.word_ready;
    assign w_boundary  = (r_state == ST_SEND_R) & w_accept;
    assign w_load_pend = r_pend_full & bus.enable & ((r_state == ST_IDLE) | w_boundary);
    assign w_underrun  = ~r_pend_full & bus.enable & w_boundary;

    // Next frame: pending data, or last frame on an underrun; zeroed by mute or zero-fill mode.
    assign w_zero  = bus.mute | (~r_pend_full & ~bus.underrun_mode);
    assign w_nxt_l = w_zero ? '0 : (r_pend_full ? r_pend_l : r_last_l);
    assign w_nxt_r = w_zero ? '0 : (r_pend_full ? r_pend_r : r_last_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_pend_full     <= 1'b0;
            r_pend_tag      <= 1'b0;
            r_pend_l        <= '0;
            r_pend_r        <= '0;
            r_last_l        <= '0;
            r_last_r        <= '0;
            r_cur_r         <= '0;
            r_data_word     <= '0;
            r_word_valid    <= 1'b0;
            r_word_is_right <= 1'b0;
            r_active_src    <= 1'b0;
            r_underrun_cnt  <= '0;
        end else begin
            // A source handshake only happens while pending is empty, so it never meets a load.
            if (w_s0_hs | w_s1_hs) begin
                r_pend_full <= 1'b1;
                r_pend_tag  <= w_s1_hs;
                r_pend_l    <= w_s1_hs ? bus.s1_left  : bus.s0_left;
                r_pend_r    <= w_s1_hs ? bus.s1_right : bus.s0_right;
            end else if (w_load_pend) begin
                r_pend_full <= 1'b0;
            end

            if (w_load_pend | w_underrun) begin
                r_state         <= ST_SEND_L;
                r_word_valid    <= 1'b1;
                r_word_is_right <= 1'b0;
                r_data_word     <= w_nxt_l;
                r_cur_r         <= w_nxt_r;
            end else if ((r_state == ST_SEND_L) && w_accept) begin
                r_state         <= ST_SEND_R;
                r_word_is_right <= 1'b1;
                r_data_word     <= r_cur_r;
            end else if (w_boundary) begin
                r_state         <= ST_IDLE;
                r_word_valid    <= 1'b0;
                r_word_is_right <= 1'b0;
            end

            // Last frame keeps pre-mute data so a repeat after unmute is meaningful.
            if (w_load_pend) begin
                r_last_l     <= r_pend_l;
                r_last_r     <= r_pend_r;
                r_active_src <= r_pend_tag;
            end

            if (w_underrun && (r_underrun_cnt != CNT_MAX)) begin
                r_underrun_cnt <= r_underrun_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_dac_frame_sched.sv
// Randomised and directed bench for dac_frame_sched against a frame-queue reference model.
module tb_dac_frame_sched;
    localparam int unsigned DW    = 24;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned SAT_W = 4;

    typedef struct packed {
        logic          tag;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } frm_t;

    typedef struct packed {
        logic          act;
        logic          rt;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic rst_sat;
    always #5 clk = ~clk;

    dac_frame_sched_if #(.DW(DW), .CNT_W(CNT_W)) u_if  ();
    dac_frame_sched_if #(.DW(DW), .CNT_W(SAT_W)) u_sif ();

    dac_frame_sched #(.DW(DW), .CNT_W(CNT_W)) u_dut (.clk(clk), .rst(rst),     .bus(u_if));
    dac_frame_sched #(.DW(DW), .CNT_W(SAT_W)) u_sat (.clk(clk), .rst(rst_sat), .bus(u_sif));

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   chk_en   = 1'b0;
    bit   gate_rand = 1'b0;
    bit   sat_done = 1'b0;
    frm_t s0_q[$];
    frm_t s1_q[$];
    ent_t log_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Reference model: a frame queue, the frame on the wire and which half is showing.
    frm_t          m_pq[$];
    logic [DW-1:0] m_cur[2];
    frm_t          m_last;
    bit            m_stream;
    bit            m_rt;
    bit            m_active;
    int            m_cnt;
    int            m_cnt_max = (1 << CNT_W) - 1;

    task automatic model_load();
        frm_t f0;
        f0       = m_pq.pop_front();
        m_cur[0] = u_if.mute ? '0 : f0.l;
        m_cur[1] = u_if.mute ? '0 : f0.r;
        m_last   = f0;
        m_active = f0.tag;
        m_rt     = 1'b0;
        m_stream = 1'b1;
    endtask

    always @(posedge clk) begin : p_model
        frm_t f;
        bit   hs;
        cyc++;
        if (rst) begin
            m_pq.delete();
            m_cur[0] = '0; m_cur[1] = '0;
            m_last = '0; m_stream = 1'b0; m_rt = 1'b0; m_active = 1'b0; m_cnt = 0;
        end else begin
            hs    = (m_pq.size() == 0) && (u_if.src_sel ? u_if.s1_valid : u_if.s0_valid);
            f.tag = u_if.src_sel;
            f.l   = u_if.src_sel ? u_if.s1_left  : u_if.s0_left;
            f.r   = u_if.src_sel ? u_if.s1_right : u_if.s0_right;
            if (!m_stream) begin
                if (u_if.enable && m_pq.size() != 0) model_load();
            end else if (u_if.word_ready) begin
                if (!m_rt) m_rt = 1'b1;
                else if (!u_if.enable) m_stream = 1'b0;
                else if (m_pq.size() != 0) model_load();
                else begin
                    if (m_cnt < m_cnt_max) m_cnt++;
                    m_cur[0] = (!u_if.underrun_mode || u_if.mute) ? '0 : m_last.l;
                    m_cur[1] = (!u_if.underrun_mode || u_if.mute) ? '0 : m_last.r;
                    m_rt = 1'b0;
                end
            end
            if (hs) m_pq.push_back(f);
        end
    end

    always @(negedge clk) begin : p_cmp
        if (chk_en) begin
            chk("word_valid", 32'(u_if.word_valid), 32'(m_stream));
            if (m_stream) begin
                chk("data_word", 32'(u_if.data_word), 32'(m_cur[m_rt]));
                chk("word_is_right", 32'(u_if.word_is_right), 32'(m_rt));
            end
            chk("active_src", 32'(u_if.active_src), 32'(m_active));
            chk("underrun_cnt", 32'(u_if.underrun_cnt), 32'(m_cnt));
            chk("s0_ready", 32'(u_if.s0_ready), 32'((m_pq.size() == 0) && !u_if.src_sel));
            chk("s1_ready", 32'(u_if.s1_ready), 32'((m_pq.size() == 0) &&  u_if.src_sel));
        end
    end

    always @(posedge clk) begin : p_log
        if (!rst && u_if.word_valid && u_if.word_ready)
            log_q.push_back('{act: u_if.active_src, rt: u_if.word_is_right, d: u_if.data_word});
    end

    // Source feeders present the head of each queue and pop on handshake.
    always @(posedge clk) begin : p_feed
        bit h0, h1;
        h0 = u_if.s0_valid && u_if.s0_ready && !rst;
        h1 = u_if.s1_valid && u_if.s1_ready && !rst;
        #1;
        if (h0 && s0_q.size() > 0) s0_q.delete(0);
        if (h1 && s1_q.size() > 0) s1_q.delete(0);
        u_if.s0_valid = (s0_q.size() > 0) && (!gate_rand || ($urandom_range(0, 3) != 0));
        u_if.s1_valid = (s1_q.size() > 0) && (!gate_rand || ($urandom_range(0, 3) != 0));
        if (s0_q.size() > 0) begin u_if.s0_left = s0_q[0].l; u_if.s0_right = s0_q[0].r; end
        if (s1_q.size() > 0) begin u_if.s1_left = s1_q[0].l; u_if.s1_right = s1_q[0].r; end
    end

    function automatic frm_t mk(input logic [DW-1:0] l, input logic [DW-1:0] r);
        mk = '{tag: 1'b0, l: l, r: r};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        log_q.delete();
    endtask

    task automatic wait_words(input int n, input string nm);
        int k = 0;
        while (log_q.size() < n && k < 60) begin step(1); k++; end
        chk(nm, 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (u_if.word_valid && k < 20) begin step(1); k++; end
        chk("idle_reached", 32'(u_if.word_valid), 32'd0);
    endtask

    // Narrow-counter instance pins saturation without tens of thousands of frames.
    initial begin : p_sat
        int k;
        u_sif.enable = 1'b1; u_sif.src_sel = 1'b0; u_sif.mute = 1'b0; u_sif.underrun_mode = 1'b1;
        u_sif.s0_valid = 1'b0; u_sif.s0_left = 24'h777777; u_sif.s0_right = 24'h888888;
        u_sif.s1_valid = 1'b0; u_sif.s1_left = '0; u_sif.s1_right = '0; u_sif.word_ready = 1'b1;
        rst_sat = 1'b1;
        step(2);
        rst_sat = 1'b0;
        u_sif.s0_valid = 1'b1;
        k = 0;
        while (!u_sif.word_valid && k < 10) begin step(1); k++; end
        u_sif.s0_valid = 1'b0;
        chk("sat_first_valid", 32'(u_sif.word_valid), 32'd1);
        step(6);
        chk("sat_cnt_mid", 32'(u_sif.underrun_cnt > 0 && u_sif.underrun_cnt < 15), 32'd1);
        step(60);
        chk("sat_cnt_max", 32'(u_sif.underrun_cnt), 32'd15);
        chk("sat_repeat", 32'(u_sif.data_word == 24'h777777 || u_sif.data_word == 24'h888888), 32'd1);
        sat_done = 1'b1;
    end

    initial begin : p_main
        int t0, t1, k, rights;
        bit s1_seen, found;
        rst = 1'b1;
        u_if.enable = 1'b0; u_if.src_sel = 1'b0; u_if.mute = 1'b0; u_if.underrun_mode = 1'b0;
        u_if.s0_valid = 1'b0; u_if.s0_left = '0; u_if.s0_right = '0;
        u_if.s1_valid = 1'b0; u_if.s1_left = '0; u_if.s1_right = '0; u_if.word_ready = 1'b0;
        step(3);
        chk_en = 1'b1;
        chk("rst_word_valid", 32'(u_if.word_valid), 32'd0);
        chk("rst_data_word", 32'(u_if.data_word), 32'd0);
        chk("rst_is_right", 32'(u_if.word_is_right), 32'd0);
        chk("rst_underrun_cnt", 32'(u_if.underrun_cnt), 32'd0);
        rst = 1'b0;
        log_q.delete();

        // Basic sequencing and load latency.
        u_if.enable = 1'b1; u_if.word_ready = 1'b1;
        s0_q.push_back(mk(24'h000001, 24'h000002));
        s0_q.push_back(mk(24'h000003, 24'h000004));
        t0 = -1; t1 = -1; s1_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (t0 < 0 && u_if.s0_valid && u_if.s0_ready) t0 = cyc;
            if (t1 < 0 && u_if.word_valid) t1 = cyc;
            if (u_if.s1_ready) s1_seen = 1'b1;
        end
        chk("load_latency", 32'(t1 - t0), 32'd2);
        chk("s1_ready_never", 32'(s1_seen), 32'd0);
        wait_words(4, "basic_words");
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            chk("basic_data", 32'(log_q[i].d), 32'(i + 1));
            chk("basic_is_right", 32'(log_q[i].rt), 32'(i % 2));
        end
        u_if.enable = 1'b0;
        wait_idle();

        // Backpressure in SEND_L with pending full.
        do_reset();
        u_if.enable = 1'b1; u_if.word_ready = 1'b0;
        s0_q.push_back(mk(24'h111111, 24'h222222));
        s0_q.push_back(mk(24'h333333, 24'h444444));
        step(8);
        chk("bp_valid", 32'(u_if.word_valid), 32'd1);
        chk("bp_hold_left", 32'(u_if.data_word), 32'h111111);
        chk("bp_s0_ready", 32'(u_if.s0_ready), 32'd0);
        u_if.word_ready = 1'b1;
        wait_words(4, "bp_words");
        if (log_q.size() >= 4) begin
            chk("bp_w0", 32'(log_q[0].d), 32'h111111);
            chk("bp_w3", 32'(log_q[3].d), 32'h444444);
        end
        u_if.enable = 1'b0;
        wait_idle();

        // Underrun repeat, then zero fill.
        do_reset();
        u_if.underrun_mode = 1'b1; u_if.enable = 1'b1;
        s0_q.push_back(mk(24'hABCDEF, 24'h123456));
        step(14);
        rights = 0;
        foreach (log_q[i]) begin
            chk("repeat_data", 32'(log_q[i].d), log_q[i].rt ? 32'h123456 : 32'hABCDEF);
            if (log_q[i].rt) rights++;
        end
        chk("repeat_some", 32'(rights >= 3), 32'd1);
        chk("repeat_cnt", 32'(u_if.underrun_cnt), 32'(rights));
        do_reset();
        u_if.underrun_mode = 1'b0;
        s0_q.push_back(mk(24'h654321, 24'h0FEDCB));
        step(12);
        chk("zero_log_len", 32'(log_q.size() >= 6), 32'd1);
        foreach (log_q[i])
            chk("zero_fill", 32'(log_q[i].d), (i == 0) ? 32'h654321 : (i == 1) ? 32'h0FEDCB : 32'd0);

        // Source switch at a frame boundary.
        do_reset();
        u_if.src_sel = 1'b0;
        s1_q.push_back('{tag: 1'b1, l: 24'h500001, r: 24'h500002});
        s0_q.push_back(mk(24'h100001, 24'h100002));
        s0_q.push_back(mk(24'h100003, 24'h100004));
        found = 1'b0; k = 0;
        while (!found && k < 30) begin
            step(1); k++;
            found = u_if.word_valid && !u_if.word_is_right && (u_if.data_word == 24'h100003);
        end
        chk("switch_seen", 32'(found), 32'd1);
        u_if.src_sel = 1'b1;
        wait_words(6, "switch_words");
        if (log_q.size() >= 6) begin
            chk("switch_s0_right", 32'(log_q[3].d), 32'h100004);
            chk("switch_s0_act", 32'(log_q[3].act), 32'd0);
            chk("switch_s1_left", 32'(log_q[4].d), 32'h500001);
            chk("switch_s1_act", 32'(log_q[4].act), 32'd1);
        end

        // Mute mid-frame, then enable drop in SEND_L.
        do_reset();
        u_if.src_sel = 1'b0; u_if.underrun_mode = 1'b0; u_if.enable = 1'b1;
        s0_q.push_back(mk(24'h200001, 24'h200002));
        s0_q.push_back(mk(24'h200003, 24'h200004));
        s0_q.push_back(mk(24'h200005, 24'h200006));
        found = 1'b0; k = 0;
        while (!found && k < 30) begin
            step(1); k++;
            found = u_if.word_valid && !u_if.word_is_right && (u_if.data_word == 24'h200001);
        end
        chk("mute_seen", 32'(found), 32'd1);
        u_if.mute = 1'b1;
        wait_words(6, "mute_words");
        if (log_q.size() >= 6) begin
            chk("mute_cur_l", 32'(log_q[0].d), 32'h200001);
            chk("mute_cur_r", 32'(log_q[1].d), 32'h200002);
            for (int i = 2; i < 6; i++) chk("mute_zero", 32'(log_q[i].d), 32'd0);
        end
        chk("mute_consumed", 32'(s0_q.size()), 32'd0);
        u_if.mute = 1'b0;
        s0_q.push_back(mk(24'h2A0001, 24'h2A0002));
        found = 1'b0; k = 0;
        while (!found && k < 30) begin
            step(1); k++;
            found = u_if.word_valid && !u_if.word_is_right && (u_if.data_word == 24'h2A0001);
        end
        chk("endrop_seen", 32'(found), 32'd1);
        u_if.enable = 1'b0;
        step(1);
        chk("endrop_right_valid", 32'(u_if.word_valid), 32'd1);
        chk("endrop_right_data", 32'(u_if.data_word), 32'h2A0002);
        step(1);
        chk("endrop_idle", 32'(u_if.word_valid), 32'd0);

        // Reset in SEND_R with pending full.
        do_reset();
        u_if.enable = 1'b1;
        s0_q.push_back(mk(24'h300001, 24'h300002));
        s0_q.push_back(mk(24'h300003, 24'h300004));
        s0_q.push_back(mk(24'h300005, 24'h300006));
        found = 1'b0; k = 0;
        while (!found && k < 30) begin
            step(1); k++;
            found = u_if.word_valid && u_if.word_is_right && !u_if.s0_ready;
        end
        chk("rstmid_seen", 32'(found), 32'd1);
        rst = 1'b1; u_if.enable = 1'b0; s0_q.delete();
        step(1);
        chk("rstmid_valid", 32'(u_if.word_valid), 32'd0);
        chk("rstmid_data", 32'(u_if.data_word), 32'd0);
        chk("rstmid_active", 32'(u_if.active_src), 32'd0);
        chk("rstmid_s0_ready", 32'(u_if.s0_ready), 32'd1);
        rst = 1'b0;
        u_if.enable = 1'b1;
        step(3);
        chk("rstmid_no_stale", 32'(u_if.word_valid), 32'd0);
        log_q.delete();
        s0_q.push_back(mk(24'h3A0001, 24'h3A0002));
        wait_words(2, "rstmid_words");
        if (log_q.size() >= 2) begin
            chk("rstmid_fresh_l", 32'(log_q[0].d), 32'h3A0001);
            chk("rstmid_fresh_r", 32'(log_q[1].d), 32'h3A0002);
        end

        // Randomised traffic against the model.
        gate_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step(1);
            rst = ($urandom_range(0, 399) == 0);
            u_if.enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0)  u_if.src_sel = ~u_if.src_sel;
            if ($urandom_range(0, 11) == 0) u_if.mute = ~u_if.mute;
            if ($urandom_range(0, 9) == 0)  u_if.underrun_mode = ~u_if.underrun_mode;
            u_if.word_ready = ($urandom_range(0, 3) != 0);
            if (s0_q.size() < 2) s0_q.push_back(mk(DW'($urandom), DW'($urandom)));
            if (s1_q.size() < 2) s1_q.push_back('{tag: 1'b1, l: DW'($urandom), r: DW'($urandom)});
            if (log_q.size() > 64) log_q.delete();
        end
        rst = 1'b0;

        k = 0;
        while (!sat_done && k < 200) begin step(1); k++; end
        chk("sat_finished", 32'(sat_done), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
